// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_pkg
// Description : Shared 640x480@60 raster constants and the sync strobe bundle
//               carried by the video delay lines.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

    // Default 640x480 @ 60 Hz geometry (pixels / lines)
    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FP      = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BP      = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FP      = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BP      = 33;

    localparam int H_TOTAL = DEF_H_VISIBLE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int V_TOTAL = DEF_V_VISIBLE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    // Sync strobes travelling together: hs/vs active-low, de active-high
    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
    } sync_bus_t;

    // Inactive level of every strobe
    localparam sync_bus_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, de: 1'b0};

endpackage
`default_nettype wire

// File: rtl/sync_delay_line.sv
`default_nettype none
// ============================================================================
// Module      : sync_delay_line
// Description : N-stage shift register for a sync_bus_t, clearing to the
//               idle strobe levels. N=0 degenerates to a plain wire.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_delay_line
    import vga_timing_pkg::*;
#(
    parameter int N = 2
) (
    input  logic      i_clk,
    input  logic      i_rst,
    input  sync_bus_t i_bus,
    output sync_bus_t o_bus
);

    generate
        if (N == 0) begin : g_wire
            // Clock and reset have no role without stages
            wire w_unused = &{1'b0, i_clk, i_rst};
            assign o_bus = i_bus;
        end else begin : g_pipe
            sync_bus_t [N-1:0] r_stage;

            // Shift one stage per clock; reset parks every stage at idle
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    for (int i = 0; i < N; i++) begin
                        r_stage[i] <= SYNC_IDLE;
                    end
                end else begin
                    r_stage[0] <= i_bus;
                    for (int i = 1; i < N; i++) begin
                        r_stage[i] <= r_stage[i-1];
                    end
                end
            end

            assign o_bus = r_stage[N-1];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/vga_scan_timing.sv
`default_nettype none
// ============================================================================
// Module      : vga_scan_timing
// Description : Raster generator. Divides clk_125MHz down to the pixel rate,
//               scans DrawX/DrawY over the full frame and emits hs/vs/vde
//               delayed to line up with the downstream colour pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_scan_timing
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV    = 5,
    parameter int H_VISIBLE  = DEF_H_VISIBLE,
    parameter int H_FP       = DEF_H_FP,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BP       = DEF_H_BP,
    parameter int V_VISIBLE  = DEF_V_VISIBLE,
    parameter int V_FP       = DEF_V_FP,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BP       = DEF_V_BP,
    parameter int SYNC_DELAY = 2
) (
    input  logic       clk_125MHz,
    input  logic       reset,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       pixel_tick,
    output logic       frame_start,
    output logic       hs,
    output logic       vs,
    output logic       vde
);

    localparam int c_H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int c_V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int c_DIV_W   = $clog2(CLK_DIV);

    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);

    localparam logic [9:0] c_H_LAST     = 10'(c_H_TOTAL - 1);
    localparam logic [9:0] c_V_LAST     = 10'(c_V_TOTAL - 1);
    localparam logic [9:0] c_H_VIS      = 10'(H_VISIBLE);
    localparam logic [9:0] c_V_VIS      = 10'(V_VISIBLE);
    localparam logic [9:0] c_HS_START   = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] c_HS_END     = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [9:0] c_VS_START   = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] c_VS_END     = 10'(V_VISIBLE + V_FP + V_SYNC - 1);

    logic [c_DIV_W-1:0] r_div;
    logic               r_tick;
    logic               r_frame_start;
    logic [9:0]         r_x;
    logic [9:0]         r_y;
    logic               w_div_last;
    logic               w_x_last;
    logic               w_y_last;
    sync_bus_t          w_raw;
    sync_bus_t          w_dly;

    assign w_div_last = (r_div == c_DIV_LAST);
    assign w_x_last   = (r_x == c_H_LAST);
    assign w_y_last   = (r_y == c_V_LAST);

    // Pixel divider; tick and frame_start are registered so both land on the
    // cycle after the divider's last count, one cycle before the counters move
    always_ff @(posedge clk_125MHz) begin
        if (reset) begin
            r_div         <= '0;
            r_tick        <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_div         <= w_div_last ? '0 : r_div + 1'b1;
            r_tick        <= w_div_last;
            r_frame_start <= w_div_last && w_x_last && w_y_last;
        end
    end

    // Raster counters advance on the edge after each tick, with explicit wraps
    always_ff @(posedge clk_125MHz) begin
        if (reset) begin
            r_x <= '0;
            r_y <= '0;
        end else if (r_tick) begin
            if (w_x_last) begin
                r_x <= '0;
                r_y <= w_y_last ? '0 : r_y + 10'd1;
            end else begin
                r_x <= r_x + 10'd1;
            end
        end
    end

    // Undelayed strobes decoded straight from the registered counters
    always_comb begin
        w_raw    = SYNC_IDLE;
        w_raw.hs = ~((r_x >= c_HS_START) && (r_x <= c_HS_END));
        w_raw.vs = ~((r_y >= c_VS_START) && (r_y <= c_VS_END));
        w_raw.de = (r_x < c_H_VIS) && (r_y < c_V_VIS);
    end

    // Align strobes with the BRAM read and colour-mapping latency
    sync_delay_line #(
        .N (SYNC_DELAY)
    ) u_sync_delay (
        .i_clk (clk_125MHz),
        .i_rst (reset),
        .i_bus (w_raw),
        .o_bus (w_dly)
    );

    assign DrawX       = r_x;
    assign DrawY       = r_y;
    assign pixel_tick  = r_tick;
    assign frame_start = r_frame_start;
    assign hs          = w_dly.hs;
    assign vs          = w_dly.vs;
    assign vde         = w_dly.de;

endmodule
`default_nettype wire

// File: tb/tb_vga_scan_timing.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_vga_scan_timing
// Description : Directed self-checking bench. Instance A uses the default
//               geometry (delay 2), Z is the same with zero delay, S is a
//               shrunken geometry (CLK_DIV 2, 15x10, delay 3) for frame-level
//               behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_scan_timing;

    logic clk_125MHz = 1'b0;
    logic reset_a;
    logic reset_b;

    logic [9:0] x_a, y_a, x_z, y_z, x_s, y_s;
    logic tick_a, fs_a, hs_a, vs_a, vde_a;
    logic tick_z, fs_z, hs_z, vs_z, vde_z;
    logic tick_s, fs_s, hs_s, vs_s, vde_s;

    int checks = 0;
    int errors = 0;

    always #4 clk_125MHz = ~clk_125MHz;

    vga_scan_timing u_dut_a (
        .clk_125MHz (clk_125MHz), .reset (reset_a),
        .DrawX (x_a), .DrawY (y_a), .pixel_tick (tick_a), .frame_start (fs_a),
        .hs (hs_a), .vs (vs_a), .vde (vde_a)
    );

    vga_scan_timing #(.SYNC_DELAY (0)) u_dut_z (
        .clk_125MHz (clk_125MHz), .reset (reset_a),
        .DrawX (x_z), .DrawY (y_z), .pixel_tick (tick_z), .frame_start (fs_z),
        .hs (hs_z), .vs (vs_z), .vde (vde_z)
    );

    vga_scan_timing #(
        .CLK_DIV (2), .H_VISIBLE (8), .H_FP (2), .H_SYNC (3), .H_BP (2),
        .V_VISIBLE (6), .V_FP (1), .V_SYNC (2), .V_BP (1), .SYNC_DELAY (3)
    ) u_dut_s (
        .clk_125MHz (clk_125MHz), .reset (reset_b),
        .DrawX (x_s), .DrawY (y_s), .pixel_tick (tick_s), .frame_start (fs_s),
        .hs (hs_s), .vs (vs_s), .vde (vde_s)
    );

    // Hold both resets for three cycles; every output must sit at its idle value
    task automatic test_reset();
        reset_a = 1'b1;
        reset_b = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk_125MHz);
            checks++; if (x_a !== 10'd0 || y_a !== 10'd0) begin errors++; $display("FAIL reset_xy c=%0d: got (%0d,%0d) expected (0,0)", c, x_a, y_a); end
            checks++; if (hs_a !== 1'b1 || vs_a !== 1'b1 || vde_a !== 1'b0) begin errors++; $display("FAIL reset_sync c=%0d: got hs=%b vs=%b vde=%b expected 1 1 0", c, hs_a, vs_a, vde_a); end
            checks++; if (tick_a !== 1'b0 || fs_a !== 1'b0) begin errors++; $display("FAIL reset_pulses c=%0d: got tick=%b fs=%b expected 0 0", c, tick_a, fs_a); end
            checks++; if (hs_z !== 1'b1 || vs_z !== 1'b1 || vde_z !== 1'b1) begin errors++; $display("FAIL reset_passthru c=%0d: got hs=%b vs=%b vde=%b expected 1 1 1", c, hs_z, vs_z, vde_z); end
            checks++; if (hs_s !== 1'b1 || vs_s !== 1'b1 || vde_s !== 1'b0 || x_s !== 10'd0) begin errors++; $display("FAIL reset_small c=%0d: got hs=%b vs=%b vde=%b x=%0d expected 1 1 0 0", c, hs_s, vs_s, vde_s, x_s); end
        end
    endtask

    // Release reset_a and check the first 20 cycles of divider/counter timing
    task automatic test_release(input string tag);
        reset_a = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk_125MHz);
            checks++; if (tick_a !== ((k % 5) == 0)) begin errors++; $display("FAIL %s_tick k=%0d: got %b expected %b", tag, k, tick_a, (k % 5) == 0); end
            checks++; if (x_a !== 10'((k - 1) / 5) || y_a !== 10'd0) begin errors++; $display("FAIL %s_xy k=%0d: got (%0d,%0d) expected (%0d,0)", tag, k, x_a, y_a, (k - 1) / 5); end
            checks++; if (vde_a !== (k >= 2)) begin errors++; $display("FAIL %s_vde k=%0d: got %b expected %b", tag, k, vde_a, k >= 2); end
            checks++; if (hs_a !== 1'b1 || vs_a !== 1'b1 || fs_a !== 1'b0) begin errors++; $display("FAIL %s_sync k=%0d: got hs=%b vs=%b fs=%b expected 1 1 0", tag, k, hs_a, vs_a, fs_a); end
            checks++; if (vde_z !== 1'b1 || x_z !== x_a) begin errors++; $display("FAIL %s_zero_delay k=%0d: got vde=%b x=%0d expected 1 %0d", tag, k, vde_z, x_z, (k - 1) / 5); end
        end
    endtask

    // Continue through line 0: hsync window, 2-cycle delay, line wrap
    task automatic test_line();
        int c656 = -1, chs_fall = -1, chs_rise = -1, cwrap = -1;
        int hs_low = 0, vs_low = 0, fs_cnt = 0;
        logic [9:0] prev_x = x_a;
        logic [9:0] wrap_x = '1;
        for (int k = 21; k <= 4100; k++) begin
            @(negedge clk_125MHz);
            if (x_a == 10'd656 && c656 < 0) c656 = k;
            if (hs_a == 1'b0 && chs_fall < 0) chs_fall = k;
            if (hs_a == 1'b1 && chs_fall >= 0 && chs_rise < 0) chs_rise = k;
            if (hs_z == 1'b0) hs_low++;
            if (vs_a == 1'b0) vs_low++;
            if (fs_a == 1'b1) fs_cnt++;
            if (y_a == 10'd1) begin
                cwrap  = k;
                wrap_x = prev_x;
                break;
            end
            prev_x = x_a;
        end
        checks++; if (c656 != 3281) begin errors++; $display("FAIL line_x656_cycle: got %0d expected 3281", c656); end
        checks++; if (chs_fall != 3283) begin errors++; $display("FAIL line_hs_fall: got %0d expected 3283", chs_fall); end
        checks++; if (chs_rise != 3763) begin errors++; $display("FAIL line_hs_rise: got %0d expected 3763", chs_rise); end
        checks++; if (hs_low != 480) begin errors++; $display("FAIL line_hs_raw_low: got %0d expected 480", hs_low); end
        checks++; if (cwrap != 4001) begin errors++; $display("FAIL line_wrap_cycle: got %0d expected 4001", cwrap); end
        checks++; if (wrap_x !== 10'd799 || x_a !== 10'd0) begin errors++; $display("FAIL line_wrap_x: got prev=%0d now=%0d expected 799 0", wrap_x, x_a); end
        checks++; if (vs_low != 0 || fs_cnt != 0) begin errors++; $display("FAIL line_quiet: got vs_low=%0d fs=%0d expected 0 0", vs_low, fs_cnt); end
    endtask

    // One-cycle reset at DrawX=300 on line 1, then the same restart sequence
    task automatic test_mid_reset_a();
        for (int n = 0; n < 2000 && x_a != 10'd300; n++) @(negedge clk_125MHz);
        checks++; if (x_a !== 10'd300 || y_a !== 10'd1) begin errors++; $display("FAIL midreset_reach: got (%0d,%0d) expected (300,1)", x_a, y_a); end
        reset_a = 1'b1;
        @(negedge clk_125MHz);
        checks++; if (x_a !== 10'd0 || y_a !== 10'd0 || tick_a !== 1'b0) begin errors++; $display("FAIL midreset_xy: got (%0d,%0d) tick=%b expected (0,0) 0", x_a, y_a, tick_a); end
        checks++; if (hs_a !== 1'b1 || vs_a !== 1'b1 || vde_a !== 1'b0) begin errors++; $display("FAIL midreset_sync: got hs=%b vs=%b vde=%b expected 1 1 0", hs_a, vs_a, vde_a); end
        checks++; if (hs_z !== 1'b1 || vde_z !== 1'b1) begin errors++; $display("FAIL midreset_passthru: got hs=%b vde=%b expected 1 1", hs_z, vde_z); end
        test_release("restart");
    endtask

    // Small geometry: one full frame of sync/de counts and the frame wrap
    task automatic test_frame_small();
        int vs_low = 0, hs_low = 0, de_hi = 0, ticks = 0, fs_cnt = 0;
        int fs_k = -1, cvs = -1;
        logic [9:0] fs_x = '1, fs_y = '1, x301 = '1, y301 = '1;
        logic vde303 = 1'bx, vde304 = 1'bx;
        reset_b = 1'b0;
        for (int k = 1; k <= 310; k++) begin
            @(negedge clk_125MHz);
            if (k >= 4 && k <= 303) begin
                if (vs_s == 1'b0) vs_low++;
                if (hs_s == 1'b0) hs_low++;
                if (vde_s == 1'b1) de_hi++;
            end
            if (k <= 300 && tick_s == 1'b1) ticks++;
            if (fs_s == 1'b1) begin fs_cnt++; fs_k = k; fs_x = x_s; fs_y = y_s; end
            if (vs_s == 1'b0 && cvs < 0) cvs = k;
            if (k == 301) begin x301 = x_s; y301 = y_s; end
            if (k == 303) vde303 = vde_s;
            if (k == 304) vde304 = vde_s;
        end
        checks++; if (vs_low != 60) begin errors++; $display("FAIL frame_vs_low: got %0d expected 60", vs_low); end
        checks++; if (hs_low != 60) begin errors++; $display("FAIL frame_hs_low: got %0d expected 60", hs_low); end
        checks++; if (de_hi != 96) begin errors++; $display("FAIL frame_vde_high: got %0d expected 96", de_hi); end
        checks++; if (ticks != 150) begin errors++; $display("FAIL frame_ticks: got %0d expected 150", ticks); end
        checks++; if (fs_cnt != 1 || fs_k != 300) begin errors++; $display("FAIL frame_start_pulse: got count=%0d at=%0d expected 1 at 300", fs_cnt, fs_k); end
        checks++; if (fs_x !== 10'd14 || fs_y !== 10'd9) begin errors++; $display("FAIL frame_start_pos: got (%0d,%0d) expected (14,9)", fs_x, fs_y); end
        checks++; if (x301 !== 10'd0 || y301 !== 10'd0) begin errors++; $display("FAIL frame_wrap_xy: got (%0d,%0d) expected (0,0)", x301, y301); end
        checks++; if (vde303 !== 1'b0 || vde304 !== 1'b1) begin errors++; $display("FAIL frame_vde_rise: got %b%b expected 01", vde303, vde304); end
        checks++; if (cvs != 214) begin errors++; $display("FAIL frame_vs_fall: got %0d expected 214", cvs); end
    endtask

    // Small geometry: reset mid-frame at (5,4), then restart timing
    task automatic test_mid_reset_small();
        for (int n = 0; n < 400 && !(x_s == 10'd5 && y_s == 10'd4); n++) @(negedge clk_125MHz);
        checks++; if (x_s !== 10'd5 || y_s !== 10'd4) begin errors++; $display("FAIL small_reach: got (%0d,%0d) expected (5,4)", x_s, y_s); end
        reset_b = 1'b1;
        @(negedge clk_125MHz);
        checks++; if (x_s !== 10'd0 || y_s !== 10'd0 || tick_s !== 1'b0 || fs_s !== 1'b0) begin errors++; $display("FAIL small_reset_xy: got (%0d,%0d) tick=%b fs=%b expected (0,0) 0 0", x_s, y_s, tick_s, fs_s); end
        checks++; if (hs_s !== 1'b1 || vs_s !== 1'b1 || vde_s !== 1'b0) begin errors++; $display("FAIL small_reset_sync: got hs=%b vs=%b vde=%b expected 1 1 0", hs_s, vs_s, vde_s); end
        reset_b = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk_125MHz);
            checks++; if (tick_s !== ((k % 2) == 0)) begin errors++; $display("FAIL small_tick k=%0d: got %b expected %b", k, tick_s, (k % 2) == 0); end
            checks++; if (x_s !== 10'((k - 1) / 2) || y_s !== 10'd0) begin errors++; $display("FAIL small_xy k=%0d: got (%0d,%0d) expected (%0d,0)", k, x_s, y_s, (k - 1) / 2); end
            checks++; if (vde_s !== (k >= 3)) begin errors++; $display("FAIL small_vde k=%0d: got %b expected %b", k, vde_s, k >= 3); end
        end
    endtask

    initial begin
        test_reset();
        test_release("release");
        test_line();
        test_mid_reset_a();
        test_frame_small();
        test_mid_reset_small();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
